// File: rtl/register_file_clr.sv
// Two-read/one-write register file with a sequential clear engine, range protection and an
// optional hardwired-zero register. Define REGFILE_BYPASS_EN for same-cycle write-through.
module register_file_clr #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  we3_i,
    input  logic [ADDR_WIDTH-1:0] a1_i,
    input  logic [ADDR_WIDTH-1:0] a2_i,
    input  logic [ADDR_WIDTH-1:0] a3_i,
    input  logic [DATA_WIDTH-1:0] wd3_i,
    output logic [DATA_WIDTH-1:0] rd1_o,
    output logic [DATA_WIDTH-1:0] rd2_o,
    output logic                  busy_o,
    output logic                  clr_done_o
);

    localparam logic [ADDR_WIDTH:0]   RegCount = (ADDR_WIDTH + 1)'(REG_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(REG_COUNT - 1);
    localparam bit                    HasZero  = (ZERO_REG != 0);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    clr_done_q;
    logic [DATA_WIDTH-1:0]   mem_q [REG_COUNT];
    logic                    busy;

    // An address is usable when implemented and not the hardwired-zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < RegCount) && !(HasZero && (a == '0));
    endfunction

    assign busy = (state_q == StClear);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StClear;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                StClear: begin
                    mem_q[cnt_q] <= '0;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_q    <= StIdle;
                        clr_done_q <= 1'b1;
                    end
                end
                StIdle: begin
                    if (we3_i && addr_ok(a3_i)) begin
                        mem_q[a3_i] <= wd3_i;
                    end
                    if (clr_i) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (!busy) begin
            if (addr_ok(a1_i)) rd1_o = mem_q[a1_i];
            if (addr_ok(a2_i)) rd2_o = mem_q[a2_i];
`ifdef REGFILE_BYPASS_EN
            if (we3_i && addr_ok(a3_i)) begin
                if (a1_i == a3_i) rd1_o = wd3_i;
                if (a2_i == a3_i) rd2_o = wd3_i;
            end
`else
`endif
        end
    end

    assign busy_o     = busy;
    assign clr_done_o = clr_done_q;

endmodule

// File: tb/tb_register_file_clr.sv
// Scoreboard bench for register_file_clr: reset clear, fill/readback, range checks, mid-clear
// reset, same-cycle write/read, and a ZERO_REG=0 instance sharing the same stimulus.
module tb_register_file_clr;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int RC = 12;

    logic          clk = 1'b0;
    logic          rst, clr, we3;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] wd3;
    logic [DW-1:0] rd1, rd2, z_rd1, z_rd2;
    logic          busy, clr_done, z_busy, z_clr_done;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string         tag;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t          sb1[$];
    exp_t          sb2[$];
    logic [DW-1:0] model[RC];

    always #5 clk = ~clk;

    register_file_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .ZERO_REG(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .we3_i(we3), .a1_i(a1), .a2_i(a2), .a3_i(a3),
        .wd3_i(wd3), .rd1_o(rd1), .rd2_o(rd2), .busy_o(busy), .clr_done_o(clr_done)
    );

    register_file_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .ZERO_REG(0)
    ) dut_nz (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .we3_i(we3), .a1_i(a1), .a2_i(a2), .a3_i(a3),
        .wd3_i(wd3), .rd1_o(z_rd1), .rd2_o(z_rd2), .busy_o(z_busy), .clr_done_o(z_clr_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (a >= RC || a == 0) return '0;
        return model[a];
    endfunction

    // Drive both read addresses, queue expectations, compare at the falling edge.
    task automatic expect_read(input string tag, input logic [AW-1:0] x1, input logic [AW-1:0] x2,
                               input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        exp_t p;
        a1 = x1;
        a2 = x2;
        sb1.push_back('{tag: {tag, "_rd1"}, exp: e1});
        sb2.push_back('{tag: {tag, "_rd2"}, exp: e2});
        @(negedge clk);
        p = sb1.pop_front();
        check_eq(p.tag, rd1, p.exp);
        p = sb2.pop_front();
        check_eq(p.tag, rd2, p.exp);
        tick();
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we3 = 1'b1;
        a3  = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
        if (a < RC && a != 0) model[a] = d;
    endtask

    // Counts edges until BUSY drops; also checks BUSY/CLR_DONE exclusivity along the way.
    task automatic wait_clear(input string tag, input bit drop_write);
        int n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (busy && clr_done) check_eq({tag, "_excl"}, 1, 0);
            if (!busy) break;
            check_eq({tag, "_done_lo"}, clr_done, 0);
            if (drop_write && n == 2) begin
                we3 = 1'b1;
                a3  = 3;
                wd3 = 16'h1234;
                a1  = 5;
                a2  = 3;
                #1;
                check_eq({tag, "_busy_rd1"}, rd1, 0);
                check_eq({tag, "_busy_rd2"}, rd2, 0);
            end else begin
                we3 = 1'b0;
            end
        end
        we3 = 1'b0;
        check_eq({tag, "_len"}, n, RC);
        check_eq({tag, "_done_pulse"}, clr_done, 1);
        tick();
        check_eq({tag, "_done_once"}, clr_done, 0);
        for (int i = 0; i < RC; i++) model[i] = '0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we3 = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        for (int i = 0; i < RC; i++) model[i] = '0;

        // 1. reset clear
        tick();
        tick();
        check_eq("rst_busy", busy, 1);
        check_eq("rst_done", clr_done, 0);
        check_eq("rst_rd1", rd1, 0);
        rst = 1'b0;
        wait_clear("clr1", 1'b0);
        for (int i = 0; i < RC; i++) expect_read("zero", AW'(i), AW'(RC - 1 - i), 0, 0);

        // 2. fill and readback
        for (int i = 1; i < RC; i++) write(AW'(i), DW'(i + 10));
        for (int i = 1; i < RC; i++)
            expect_read("fill", AW'(i), AW'(i), DW'(i + 10), DW'(i + 10));
        write(0, 16'h00FF);
        expect_read("reg0", 0, 0, 0, 0);
        check_eq("nz_reg0_ff", z_rd1, 16'h00FF);

        // 3. out-of-range
        write(13, 16'hBEEF);
        expect_read("oor13", 13, 12, 0, 0);
        expect_read("oor_r1", 1, 15, 11, 0);

        // 5. same-cycle write/read
        we3 = 1'b1; a3 = 5; wd3 = 16'hA5A5; a1 = 5; a2 = 5;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check_eq("same_rd1", rd1, 16'hA5A5);
        check_eq("same_rd2", rd2, 16'hA5A5);
`else
        check_eq("same_rd1", rd1, 15);
        check_eq("same_rd2", rd2, 15);
`endif
        tick();
        we3 = 1'b0;
        model[5] = 16'hA5A5;
        expect_read("after_wr", 5, 5, 16'hA5A5, 16'hA5A5);

        // 6. ZERO_REG=0 instance
        write(0, 16'h0007);
        a1 = 0;
        @(negedge clk);
        check_eq("nz_reg0", z_rd1, 16'h0007);
        check_eq("z_reg0", rd1, 0);
        tick();

        // 4. clear request, mid-clear reset, dropped write
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("clr_busy", busy, 1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_busy", busy, 1);
        wait_clear("clr2", 1'b1);
        expect_read("post_clr", 3, 5, model_rd(3), model_rd(5));
        expect_read("post_clr_b", 11, 0, model_rd(11), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file_clr.md
# register_file_clr

Parametrised two-read/one-write register file for the single-cycle RISC-V datapath. It adds four things to the basic register array: an optional hardwired-zero register, a sequential clear engine started by reset or on request, out-of-range address protection, and an optional write-to-read bypass. It sits between the decode stage (A1/A2/A3) and the ALU/writeback path (RD1/RD2/WD3).

## Interface
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: address width.
- REG_COUNT, 32: number of implemented registers, 1..2^ADDR_WIDTH.
- ZERO_REG, 1: 1 means register 0 is hardwired to zero; 0 means it is an ordinary register.

- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- CLR  input  1  request a full clear; sampled only in IDLE.
- WE3  input  1  write enable.
- A1  input  ADDR_WIDTH  read address, port 1.
- A2  input  ADDR_WIDTH  read address, port 2.
- A3  input  ADDR_WIDTH  write address.
- WD3  input  DATA_WIDTH  write data.
- RD1  output  DATA_WIDTH  read data, port 1; combinational.
- RD2  output  DATA_WIDTH  read data, port 2; combinational.
- BUSY  output  1  high while a clear is in progress.
- CLR_DONE  output  1  one-cycle pulse when a clear completes.

## Operation
- States: CLEAR and IDLE. A counter CNT of ADDR_WIDTH bits tracks the clear position.
- RST high at an edge:
  - state goes to CLEAR, CNT goes to 0, CLR_DONE goes to 0.
  - The array is not written on that edge.
  - This applies in any state, including mid-clear; the clear restarts from 0.
- CLEAR, RST low, at each edge:
  - mem[CNT] is written to 0 and CNT increments.
  - On the edge that writes CNT == REG_COUNT-1: state goes to IDLE and CLR_DONE goes to 1 for one cycle.
- IDLE with CLR=1 at an edge: state goes to CLEAR and CNT goes to 0. A WE3 write in that same cycle is still performed, and the clear later zeroes it.
- While BUSY=1:
  - CLR and WE3 are ignored; the write is dropped, not queued.
  - RD1 and RD2 are forced to 0.
- Writes in IDLE:
  - When WE3=1, mem[A3] is written with WD3 at the edge.
  - The write is suppressed if A3 >= REG_COUNT, or if ZERO_REG=1 and A3 == 0.
- Reads:
  - RDx = mem[Ax].
  - RDx = 0 if Ax >= REG_COUNT, or if ZERO_REG=1 and Ax == 0.
- Both read ports may address the same register, and either may equal A3.
- Output reset values: while RST is high and through the clear, BUSY=1, RD1=RD2=0 and CLR_DONE=0.

## Timing
- Read latency is 0 cycles (combinational from the A inputs). Write latency is 1 edge.
- Without bypass, a read of A3 in the write cycle returns the old value; the new value is visible after the edge.
- Clear duration: BUSY is high for exactly REG_COUNT edges after the first edge with RST (or CLR in IDLE) low. The request edge itself is not counted.
- After RST deasserts, the first accepted write is at edge REG_COUNT+1.
- CLR_DONE is high during the first IDLE cycle only. BUSY and CLR_DONE are never high together.
- The CNT wrap is never reached, because the transition happens at REG_COUNT-1. REG_COUNT = 2^ADDR_WIDTH must therefore not overflow CNT.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: when WE3=1, BUSY=0, A3 == Ax and A3 is a writable address, RDx = WD3 in the same cycle (write-through). The two ports are bypassed independently.
- Undefined: no bypass; RDx shows the stored value until the edge.
- Bypass never applies to register 0 when ZERO_REG=1, to out-of-range addresses, or while BUSY.

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=4, REG_COUNT=12, ZERO_REG=1 unless noted.
1. Reset clear:
   - Stimulus: RST high for 2 edges, then low.
   - Required: BUSY=1 for exactly 12 further edges; CLR_DONE pulses once; all registers read 0.
2. Fill and readback:
   - Stimulus: write i+10 to register i for i=1..11, then read A1=A2=i.
   - Required: RDx = i+10. Writing 0x00FF to register 0 leaves RD1=0.
3. Out-of-range:
   - Stimulus: WE3 with A3=13 and WD3=0xBEEF; then read A1=13; then read A1=1.
   - Required: A1=13 reads 0, and register 1 is unchanged (11).
4. Mid-clear reset and ignored write:
   - Stimulus: assert CLR; after 5 edges pulse RST; issue WE3 (A3=3, WD3=0x1234) during BUSY.
   - Required: BUSY lasts 12 edges from RST release; register 3 reads 0 afterwards.
5. Same-cycle write/read:
   - Stimulus: WE3=1, A3=A1=A2=5, WD3=0xA5A5, old value 15.
   - Required: RD1=RD2=0xA5A5 with REGFILE_BYPASS_EN defined, 15 without it; both read 0xA5A5 after the edge.
6. ZERO_REG=0:
   - Stimulus: write 0x0007 to register 0.
   - Required: RD1 with A1=0 reads 0x0007 after the edge.
